mem_access_ctrl: RTL and testbench

//  Upstream request stage for the single-port memory. Accepts read/write requests over a

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/req_fifo.sv | 55 +++++
 rtl/mem_access_ctrl.sv | 105 ++++++++++
 tb/tb_mem_access_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory request path: FSM state encoding and the
// request record carried through the request FIFO.
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    RD_WAIT
  } state_e;

  typedef struct packed {
    logic                  wr;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/req_fifo.sv
// In-order request buffer. The head entry is read combinationally so the
// issuing FSM can pop and drive the memory in the same edge.
module req_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  mem_req_t       push_data,
  input  logic           pop,
  output mem_req_t       head,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  mem_req_t         mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Request stage for a single-port memory: buffers requests, issues them in
// order as one-cycle rd_en/wr_en pulses and returns read data on rsp_valid.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_en,
  output logic              rd_en,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e           state_reg;
  logic [1:0]       wait_reg;
  mem_req_t         push_req;
  mem_req_t         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             issue_slot;
  logic             pop;

  assign push_req = '{wr: req_wr, addr: req_addr, wdata: req_wdata};

  req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign req_ready = !fifo_full;
  assign busy      = (fifo_count != '0) || (state_reg != IDLE);

  // A new request may be issued from IDLE, after a write, or on the final
  // wait cycle of a read (overlapping the response strobe).
  assign issue_slot = (state_reg == IDLE) || (state_reg == WRITE) ||
                      ((state_reg == RD_WAIT) && (wait_reg == '0));
  assign pop        = issue_slot && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      wait_reg  <= '0;
      addr      <= '0;
      wdata     <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      rsp_valid <= 1'b0;
      case (state_reg)
        WRITE: state_reg <= IDLE;
        READ: begin
          state_reg <= RD_WAIT;
          wait_reg  <= 2'(RD_LAT - 1);
        end
        RD_WAIT: begin
          if (wait_reg != '0) begin
            wait_reg <= wait_reg - 1'b1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
      // Issue overrides the fall-back to IDLE; only one enable is ever loaded.
      if (pop) begin
        state_reg <= head.wr ? WRITE : READ;
        addr      <= head.addr;
        wr_en     <= head.wr;
        rd_en     <= !head.wr;
        if (head.wr) wdata <= head.wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural one-cycle-latency
// memory; monitors log every issued operation and response.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_wr = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [3:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wdata;
  logic [7:0] rdata = '0;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int both_cnt = 0;
  int wr_a[$], wr_d[$], wr_c[$], rd_a[$], rd_c[$], rs_d[$], rs_c[$];
  logic [7:0] mem [16] = '{default: 8'h00};

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(4), .RD_LAT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .addr      (addr),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy)
  );

  // Single-port memory, read data valid one cycle after sampled rd_en.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) mem[addr] <= wdata;
    if (rd_en) rdata <= mem[addr];
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en && rd_en) both_cnt++;
      if (wr_en) begin wr_a.push_back(int'(addr)); wr_d.push_back(int'(wdata)); wr_c.push_back(cyc); end
      if (rd_en) begin rd_a.push_back(int'(addr)); rd_c.push_back(cyc); end
      if (rsp_valid) begin rs_d.push_back(int'(rsp_rdata)); rs_c.push_back(cyc); end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge and hold it until accepted; returns at the
  // negedge after the accepting posedge.
  task automatic push(input logic wr, input logic [3:0] a, input logic [7:0] d, output int waits);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    waits = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin
        @(negedge clk);
        return;
      end
      waits++;
      @(negedge clk);
    end
    chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 60 && rs_d.size() < n; i++) @(negedge clk);
    chk("rsp_timeout", 32'(rs_d.size() >= n), 32'd1);
  endtask

  task automatic wait_wr(input int n);
    for (int i = 0; i < 60 && wr_a.size() < n; i++) @(negedge clk);
    chk("wr_timeout", 32'(wr_a.size() >= n), 32'd1);
  endtask

  initial begin
    int w, bw, br, brd;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Write then read same address
    push(1'b1, 4'd3, 8'hA5, w);
    push(1'b0, 4'd3, 8'h00, w);
    req_valid = 1'b0;
    wait_rsp(1);
    chk("t2_wr_addr", 32'(wr_a[0]), 32'd3);
    chk("t2_wr_data", 32'(wr_d[0]), 32'hA5);
    chk("t2_rd_addr", 32'(rd_a[0]), 32'd3);
    chk("t2_rsp_data", 32'(rs_d[0]), 32'hA5);
    chk("t2_rsp_latency", 32'(rs_c[0] - rd_c[0]), 32'd2);
    chk("t2_order", 32'(rd_c[0] > wr_c[0]), 32'd1);
    $display("t2: rd cycle %0d rsp cycle %0d data %0h", rd_c[0], rs_c[0], rs_d[0]);

    // Reads back up the queue, then four writes fill it; a fifth is held off
    repeat (3) @(negedge clk);
    bw = wr_a.size(); br = rs_d.size();
    push(1'b0, 4'd3, 8'h00, w);
    push(1'b0, 4'd5, 8'h00, w);
    push(1'b0, 4'd3, 8'h00, w);
    for (int i = 0; i < 4; i++) push(1'b1, 4'(i), 8'h10 + 8'(i), w);
    chk("t3_full_ready", 32'(req_ready), 32'd0);
    push(1'b1, 4'd4, 8'h14, w);
    req_valid = 1'b0;
    chk("t5_stall_cycles", 32'(w), 32'd1);
    wait_wr(bw + 5);
    wait_rsp(br + 3);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_wr_addr%0d", i), 32'(wr_a[bw+i]), 32'(i));
      chk($sformatf("t3_wr_data%0d", i), 32'(wr_d[bw+i]), 32'h10 + 32'(i));
      if (i > 0) chk($sformatf("t3_wr_consec%0d", i), 32'(wr_c[bw+i] - wr_c[bw]), 32'(i));
    end
    chk("t3_rsp0", 32'(rs_d[br]), 32'hA5);
    chk("t3_rsp1", 32'(rs_d[br+1]), 32'h00);
    chk("t3_rsp2", 32'(rs_d[br+2]), 32'hA5);
    $display("t3/t5: writes from cycle %0d, stall %0d", wr_c[bw], w);

    // Alternating write/read stream
    repeat (3) @(negedge clk);
    br = rs_d.size(); brd = rd_a.size();
    push(1'b1, 4'd8, 8'h11, w);  push(1'b0, 4'd8, 8'h00, w);
    push(1'b1, 4'd9, 8'h22, w);  push(1'b0, 4'd9, 8'h00, w);
    push(1'b1, 4'd8, 8'h33, w);  push(1'b0, 4'd8, 8'h00, w);
    push(1'b1, 4'd10, 8'h44, w); push(1'b0, 4'd9, 8'h00, w);
    req_valid = 1'b0;
    wait_rsp(br + 4);
    chk("t4_rsp0", 32'(rs_d[br]), 32'h11);
    chk("t4_rsp1", 32'(rs_d[br+1]), 32'h22);
    chk("t4_rsp2", 32'(rs_d[br+2]), 32'h33);
    chk("t4_rsp3", 32'(rs_d[br+3]), 32'h22);
    chk("t4_rd_addr3", 32'(rd_a[brd+3]), 32'd9);
    chk("t4_excl", 32'(both_cnt), 32'd0);
    $display("t4: responses %0h %0h %0h %0h", rs_d[br], rs_d[br+1], rs_d[br+2], rs_d[br+3]);

    // Reset during RD_WAIT with two writes still queued
    repeat (3) @(negedge clk);
    bw = wr_a.size(); br = rs_d.size(); brd = rd_a.size();
    push(1'b0, 4'd3, 8'h00, w);
    push(1'b1, 4'd7, 8'h77, w);
    push(1'b1, 4'd6, 8'h66, w);
    req_valid = 1'b0;
    chk("t6_read_issued", 32'(rd_a.size()), 32'(brd + 1));
    chk("t6_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("t6_rst_addr", 32'(addr), 32'd0);
    chk("t6_rst_wdata", 32'(wdata), 32'd0);
    chk("t6_rst_en", 32'({wr_en, rd_en}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_req_ready", 32'(req_ready), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    chk("t6_no_rsp", 32'(rs_d.size()), 32'(br));
    chk("t6_fifo_lost", 32'(wr_a.size()), 32'(bw));
    chk("final_excl", 32'(both_cnt), 32'd0);
    $display("t6: responses after reset %0d, writes after reset %0d", rs_d.size() - br, wr_a.size() - bw);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
